// File: rtl/result_writeback_ctrl.sv
// Packs pairs of 32-bit ALU results into 64-bit words and writes them
// to consecutive memory addresses over a write/ack port.
module result_writeback_ctrl #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int ADDR_W        = 10,
  parameter int CNT_W         = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        wr_base_addr_i,
  input  logic [CNT_W-1:0]         num_results_i,
  input  logic                     res_valid_i,
  input  logic [DATA_W-1:0]        res_data_i,
  output logic                     res_ready_o,
  output logic                     loc_sel_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata_o,
  input  logic                     mem_ack_i,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [2:0] {
    IDLE,
    FILL_LO,
    FILL_HI,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [MEM_WORD_SIZE-1:0] pack;
  logic [ADDR_W-1:0]        addr;
  logic [CNT_W-1:0]         remain;
  logic                     sel_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = (num_results_i == '0) ? DONE : FILL_LO;
        end
      end
      FILL_LO: begin
        if (res_valid_i) begin
          state_nxt = (remain == CNT_W'(1)) ? WRITE : FILL_HI;
        end
      end
      FILL_HI: begin
        if (res_valid_i) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack_i) begin
          state_nxt = (remain == '0) ? DONE : FILL_LO;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // sel_q remembers which half was filled last so WRITE can keep showing it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pack   <= '0;
      addr   <= '0;
      remain <= '0;
      sel_q  <= 1'b0;
    end else begin
      if (state == IDLE && start_i) begin
        addr   <= wr_base_addr_i;
        remain <= num_results_i;
      end
      if (state == FILL_LO && res_valid_i) begin
        pack   <= {{(MEM_WORD_SIZE-DATA_W){1'b0}}, res_data_i};
        remain <= remain - CNT_W'(1);
        sel_q  <= 1'b0;
      end
      if (state == FILL_HI && res_valid_i) begin
        pack[MEM_WORD_SIZE-1:DATA_W] <= res_data_i;
        remain <= remain - CNT_W'(1);
        sel_q  <= 1'b1;
      end
      if (state == WRITE && mem_ack_i) begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    res_ready_o = 1'b0;
    loc_sel_o   = sel_q;
    mem_we_o    = 1'b0;
    done_o      = 1'b0;
    unique case (state)
      FILL_LO: begin
        res_ready_o = 1'b1;
        loc_sel_o   = 1'b0;
      end
      FILL_HI: begin
        res_ready_o = 1'b1;
        loc_sel_o   = 1'b1;
      end
      WRITE:   mem_we_o = 1'b1;
      DONE:    done_o   = 1'b1;
      default: ;
    endcase
  end

  assign busy_o      = (state != IDLE);
  assign mem_addr_o  = addr;
  assign mem_wdata_o = pack;

endmodule
